// File: rtl/dff_bist.sv
// dff_bist: six-step BIST sequencer for an async set/reset D flip-flop under test.
// Optional macro DFF_BIST_LOOP_EN: repeats passes while start stays high and adds loop_cnt.
module dff_bist #(
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       dut_d,
    output logic       dut_reset,
    output logic       dut_set,
    input  logic       dut_q,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] fail_mask,
    output logic [2:0] err_cnt
`ifdef DFF_BIST_LOOP_EN
    ,
    output logic [7:0] loop_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [2:0] LAST_STEP = 3'd5;

    state_t     state, state_nx;
    logic [2:0] step, step_nx;
    logic [7:0] hold, hold_nx;
    logic       launch, step_end, pass_end, miss;
    logic       d_nx, rst_nx, set_nx;
    logic       busy_nx, done_nx, pass_nx;
    logic [5:0] mask_nx;
    logic [2:0] err_nx;
`ifdef DFF_BIST_LOOP_EN
    logic [7:0] loop_nx;
`endif

    // Stimulus pins {D, RESET, SET} for each step.
    function automatic logic [2:0] stim_pins(input logic [2:0] s);
        case (s)
            3'd0:    return 3'b010;
            3'd1:    return 3'b100;
            3'd2:    return 3'b000;
            3'd3:    return 3'b001;
            3'd4:    return 3'b110;
            3'd5:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic exp_q(input logic [2:0] s);
        case (s)
            3'd1, 3'd3, 3'd5: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            step  <= '0;
            hold  <= '0;
        end else begin
            state <= state_nx;
            step  <= step_nx;
            hold  <= hold_nx;
        end
    end

    always_comb begin
        launch   = (state != S_RUN) && start;
        step_end = (state == S_RUN) && (hold == HOLD_LAST);
        pass_end = step_end && (step == LAST_STEP);
        state_nx = state;
        step_nx  = step;
        hold_nx  = hold;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nx = S_RUN;
                    step_nx  = '0;
                    hold_nx  = '0;
                end
            end
            S_RUN: begin
                if (step_end) begin
                    hold_nx = '0;
                    if (pass_end) begin
                        step_nx = '0;
`ifdef DFF_BIST_LOOP_EN
                        if (!start) state_nx = S_DONE;
`else
                        state_nx = S_DONE;
`endif
                    end else begin
                        step_nx = step + 3'd1;
                    end
                end else begin
                    hold_nx = hold + 8'd1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Next values for the registered outputs; pins follow the step about to be held.
    always_comb begin
        miss    = step_end && (dut_q != exp_q(step));
        mask_nx = fail_mask;
        err_nx  = err_cnt;
        if (launch) begin
            mask_nx = '0;
            err_nx  = '0;
        end else if (miss) begin
            mask_nx = fail_mask | (6'd1 << step);
`ifdef DFF_BIST_LOOP_EN
            err_nx  = (err_cnt == 3'd7) ? err_cnt : err_cnt + 3'd1;
`else
            err_nx  = err_cnt + 3'd1;
`endif
        end
`ifdef DFF_BIST_LOOP_EN
        loop_nx = loop_cnt;
        if (pass_end && (loop_cnt != 8'hFF)) loop_nx = loop_cnt + 8'd1;
`endif
        busy_nx = (state_nx == S_RUN);
        done_nx = (state_nx == S_DONE);
        pass_nx = done_nx && (mask_nx == '0);
        {d_nx, rst_nx, set_nx} = (state_nx == S_RUN) ? stim_pins(step_nx) : 3'b000;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dut_d     <= 1'b0;
            dut_reset <= 1'b1;
            dut_set   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
            err_cnt   <= '0;
`ifdef DFF_BIST_LOOP_EN
            loop_cnt  <= '0;
`endif
        end else begin
            dut_d     <= d_nx;
            dut_reset <= rst_nx;
            dut_set   <= set_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            pass      <= pass_nx;
            fail_mask <= mask_nx;
            err_cnt   <= err_nx;
`ifdef DFF_BIST_LOOP_EN
            loop_cnt  <= loop_nx;
`endif
        end
    end

endmodule

// File: tb/tb_dff_bist.sv
// tb_dff_bist: directed and random checks of dff_bist against behavioural flip-flop models.
module tb_dff_bist;

    localparam int unsigned H = 3;
`ifdef DFF_BIST_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       start = 1'b0;
    logic       dut_d, dut_reset, dut_set, dut_q;
    logic       busy, done, pass;
    logic [5:0] fail_mask;
    logic [2:0] err_cnt;
`ifdef DFF_BIST_LOOP_EN
    logic [7:0] loop_cnt;
`endif

    int   total = 0;
    int   bad = 0;
    int   mode = 0;        // 0 good, 1 stuck0, 2 stuck1, 3 set pin open, 4 forced per step
    logic q_force = 1'b0;
    logic ff_good, ff_noset;
    logic [5:0] rq;

    // {D, RESET, SET} per step, and expected-Q vector (bit n = step n).
    logic [2:0] pins_tab [6] = '{3'b010, 3'b100, 3'b000, 3'b001, 3'b110, 3'b001};
    localparam logic [5:0] EXP_Q = 6'b101010;

    always #5 clk = ~clk;

    dff_bist #(.HOLD_CYCLES(H)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .dut_d     (dut_d),
        .dut_reset (dut_reset),
        .dut_set   (dut_set),
        .dut_q     (dut_q),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_mask (fail_mask),
        .err_cnt   (err_cnt)
`ifdef DFF_BIST_LOOP_EN
        ,
        .loop_cnt  (loop_cnt)
`endif
    );

    always @(posedge clk or posedge dut_reset or posedge dut_set) begin
        if (dut_reset)    ff_good <= 1'b0;
        else if (dut_set) ff_good <= 1'b1;
        else              ff_good <= dut_d;
    end

    always @(posedge clk or posedge dut_reset) begin
        if (dut_reset) ff_noset <= 1'b0;
        else           ff_noset <= dut_d;
    end

    always_comb begin
        case (mode)
            0:       dut_q = ff_good;
            1:       dut_q = 1'b0;
            2:       dut_q = 1'b1;
            3:       dut_q = ff_noset;
            default: dut_q = q_force;
        endcase
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".busy"}, 8'(busy), 8'd0);
        chk({tag, ".done"}, 8'(done), 8'd0);
        chk({tag, ".pass"}, 8'(pass), 8'd0);
        chk({tag, ".mask"}, 8'(fail_mask), 8'd0);
        chk({tag, ".err"}, 8'(err_cnt), 8'd0);
        chk({tag, ".pins"}, 8'({dut_d, dut_reset, dut_set}), 8'b010);
    endtask

    // One run launched by a single-cycle start pulse; checks every stimulus cycle and the result.
    task automatic do_run(input int m, input logic [5:0] q_steps, input logic [5:0] emask,
                          input string tag, input bit noise);
        logic [2:0] ecnt;
        ecnt    = 3'($countones(emask));
        mode    = m;
        q_force = q_steps[0];
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 6; n++) begin
            q_force = q_steps[n];
            for (int unsigned c = 0; c < H; c++) begin
                chk($sformatf("%s.s%0d.busy", tag, n), 8'(busy), 8'd1);
                chk($sformatf("%s.s%0d.done", tag, n), 8'(done), 8'd0);
                chk($sformatf("%s.s%0d.pins", tag, n), 8'({dut_d, dut_reset, dut_set}),
                    8'(pins_tab[n]));
                if (noise && !LOOP) start = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        chk({tag, ".end.busy"}, 8'(busy), 8'd0);
        chk({tag, ".end.done"}, 8'(done), 8'd1);
        chk({tag, ".end.pass"}, 8'(pass), 8'(emask == 6'd0));
        chk({tag, ".end.mask"}, 8'(fail_mask), 8'(emask));
        chk({tag, ".end.err"}, 8'(err_cnt), 8'(ecnt));
        chk({tag, ".end.pins"}, 8'({dut_d, dut_reset, dut_set}), 8'd0);
        @(posedge clk); #1;
        chk({tag, ".hold.done"}, 8'(done), 8'd1);
        chk({tag, ".hold.mask"}, 8'(fail_mask), 8'(emask));
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #2;
        chk_reset_vals("rst");
        @(posedge clk); #1;
        chk("rst.inreset.dut_reset", 8'(dut_reset), 8'd1);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rel.dut_reset", 8'(dut_reset), 8'd0);
        chk("rel.busy", 8'(busy), 8'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle.busy", 8'(busy), 8'd0);
        chk("idle.done", 8'(done), 8'd0);

        do_run(0, 6'd0, 6'b000000, "good", 1'b0);
        do_run(1, 6'd0, 6'b101010, "stuck0", 1'b0);
        do_run(2, 6'd0, 6'b010101, "stuck1", 1'b0);
        do_run(3, 6'd0, 6'b101000, "noset", 1'b0);
        for (int i = 0; i < 8; i++) begin
            rq = 6'($urandom);
            do_run(4, rq, rq ^ EXP_Q, $sformatf("rand%0d", i), 1'b1);
        end

        if (!LOOP) begin
            // start held through DONE: one DONE cycle, then a fresh run with cleared results.
            mode  = 1;
            start = 1'b1;
            @(posedge clk); #1;
            repeat (6 * H) @(posedge clk);
            #1;
            chk("held.done", 8'(done), 8'd1);
            chk("held.mask", 8'(fail_mask), 8'b101010);
            mode = 0;
            @(posedge clk); #1;
            chk("held.rerun.done", 8'(done), 8'd0);
            chk("held.rerun.busy", 8'(busy), 8'd1);
            chk("held.rerun.mask", 8'(fail_mask), 8'd0);
            chk("held.rerun.err", 8'(err_cnt), 8'd0);
            chk("held.rerun.pins", 8'({dut_d, dut_reset, dut_set}), 8'b010);
            start = 1'b0;
            repeat (6 * H) @(posedge clk);
            #1;
            chk("held.end.done", 8'(done), 8'd1);
            chk("held.end.pass", 8'(pass), 8'd1);
        end

        // Reset during step 3 of a failing run.
        mode  = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3 * H + 1) @(posedge clk);
        #1;
        chk("mid.pre.mask", 8'(fail_mask), 8'b000010);
        chk("mid.pre.pins", 8'({dut_d, dut_reset, dut_set}), 8'b001);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("mid.rst");
        #2 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid.idle.busy", 8'(busy), 8'd0);
        chk("mid.idle.done", 8'(done), 8'd0);
        chk("mid.idle.dut_reset", 8'(dut_reset), 8'd0);
        chk("mid.idle.mask", 8'(fail_mask), 8'd0);
        do_run(0, 6'd0, 6'b000000, "fresh", 1'b0);

`ifdef DFF_BIST_LOOP_EN
        @(posedge clk); #1;
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        mode  = 0;
        start = 1'b1;
        @(posedge clk); #1;
        repeat (6 * H) @(posedge clk);
        #1;
        chk("loop.p1.busy", 8'(busy), 8'd1);
        chk("loop.p1.done", 8'(done), 8'd0);
        chk("loop.p1.cnt", loop_cnt, 8'd1);
        repeat (12 * H - 1) @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("loop.end.done", 8'(done), 8'd1);
        chk("loop.end.busy", 8'(busy), 8'd0);
        chk("loop.end.pass", 8'(pass), 8'd1);
        chk("loop.end.cnt", loop_cnt, 8'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/dff_bist.md
# dff_bist

Built-in self-test sequencer for the asynchronous set/reset D flip-flop primitive. On START it drives a fixed six-step stimulus sequence onto a flip-flop instance's D, RESET and SET pins. At the end of each step it samples Q and compares it with the expected value. It records per-step failures, then reports PASS/FAIL. It sits beside each flip-flop under test in the FPGA bring-up image and replaces the simulation-only stimulus with synthesizable hardware.

## Interface
- HOLD_CYCLES, 2: clock cycles each step's stimulus is held; legal range 2..255; Q is sampled on the last edge of the window.
- CLK  in  1  rising-edge clock for the sequencer and the flip-flop under test.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  level; sampled in IDLE or DONE to launch a run.
- DUT_D  out  1  D stimulus to the flip-flop under test.
- DUT_RESET  out  1  active-high async reset stimulus.
- DUT_SET  out  1  active-high async set stimulus.
- DUT_Q  in  1  Q returned from the flip-flop under test.
- BUSY  out  1  high while a run is in progress.
- DONE  out  1  high in DONE state, until the next run starts.
- PASS  out  1  valid while DONE; 1 when FAIL_MASK is 0.
- FAIL_MASK  out  6  bit n set if step n miscompared.
- ERR_CNT  out  3  number of miscompared steps in the current run (0..6).
- LOOP_CNT  out  8  completed passes, saturating at 255; present only with DFF_BIST_LOOP_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE to RUN when START=1. DONE to RUN when START=1. RUN to DONE after step 5 is checked.
- START is ignored while in RUN.
- Entering RUN clears FAIL_MASK and ERR_CNT, and sets step=0 and hold counter=0.
- Step stimulus, given as (D, RESET, SET → expected Q):
  - step 0: 0, 1, 0 → 0
  - step 1: 1, 0, 0 → 1
  - step 2: 0, 0, 0 → 0
  - step 3: 0, 0, 1 → 1
  - step 4: 1, 1, 0 → 0
  - step 5: 0, 0, 1 → 1
- In IDLE and DONE, the DUT pins are driven D=0, RESET=0, SET=0.
- On a miscompare: FAIL_MASK[step] is set and ERR_CNT increments. ERR_CNT cannot exceed 6, so no saturation logic is needed.
- RESET and SET are never asserted together. The DUT's priority between them is out of scope.
- All outputs are registered.

## Timing
- Reset values:
  - DUT_RESET=1, so the DUT is held cleared while the BIST is in reset.
  - DUT_D=0, DUT_SET=0.
  - BUSY=0, DONE=0, PASS=0, FAIL_MASK=0, ERR_CNT=0, LOOP_CNT=0.
  - State is IDLE.
- First clock edge after RESET_N deasserts: DUT_RESET drops to 0.
- START sampled high on edge k: BUSY=1 and the step-0 stimulus appear after edge k.
- Step n stimulus is driven in cycles k+n·H .. k+(n+1)·H−1, where H=HOLD_CYCLES.
- DUT_Q is compared on edge k+(n+1)·H. The next step's stimulus is applied on that same edge.
- Edge k+6·H: BUSY=0, DONE=1, and PASS/FAIL_MASK/ERR_CNT are final.
- Run length is therefore 6·H cycles.
- RESET_N asserted mid-run: all outputs return to their reset values immediately (asynchronously). The run is abandoned and no partial result is retained.
- START held high through DONE: a new run starts on the edge after DONE is entered. DONE is high for exactly one cycle in that case.

## Configuration
- Macro: DFF_BIST_LOOP_EN.
- Undefined: single run per START, behaving as described above. The LOOP_CNT port is absent.
- Defined: at the end of step 5, if START=1 the FSM returns to step 0 without entering DONE.
  - FAIL_MASK accumulates (bitwise OR) across passes.
  - ERR_CNT saturates at 7.
  - LOOP_CNT increments, saturating at 255.
  - DONE is entered after the first pass that completes with START=0.

## Test plan
- Correct behavioural DFF, H=2, START pulsed 1 cycle → BUSY for 12 cycles, then DONE=1, PASS=1, FAIL_MASK=6'b000000, ERR_CNT=0.
- Q stuck at 0 → DONE with PASS=0, FAIL_MASK=6'b101010, ERR_CNT=3.
- Q stuck at 1 → FAIL_MASK=6'b010101, ERR_CNT=3.
- DUT with SET pin disconnected (Q follows D on clock, reset works) → FAIL_MASK=6'b101000, ERR_CNT=2.
- RESET_N pulsed low during step 3, H=4:
  - → all outputs at reset values immediately, DUT_RESET=1.
  - → after release, stays IDLE until START; a fresh run gives PASS=1.
- With DFF_BIST_LOOP_EN: START held high for 3·6·H cycles with a good DUT, then released → LOOP_CNT=3 (or 4 if release falls mid-pass), DONE=1, PASS=1.
